// File: rtl/ct_f_spsram_128x104_ctrl.sv
// ---------------------------------------------------------------------------
// ct_f_spsram_128x104_ctrl
//
// Request-side controller for the 128x104 single-port SRAM wrapper. After
// reset it zero-fills every entry with one write per cycle. It then accepts
// read/write requests on a valid/ready handshake and returns read data
// through a 2-entry in-order response buffer.
//
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   req_vld/req_rdy   request handshake (transfer on req_vld && req_rdy)
//   req_wr            1 = write, 0 = read
//   req_addr          entry address
//   req_wdata         write data
//   req_lane_en       per-lane write enable, lane i = bits [26i+25:26i]
//   rsp_vld/rsp_rdy   read response handshake
//   rsp_data          read data
//   init_done         zero-fill sweep finished
//   sram_A/CEN/D/GWEN/WEN   SRAM request pins (CEN/GWEN/WEN active low)
//   sram_Q            SRAM read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module ct_f_spsram_128x104_ctrl #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 104,
    parameter int WRAP_SIZE  = 26,
    parameter bit INIT_EN    = 1'b1
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             req_vld,
    output logic                             req_rdy,
    input  logic                             req_wr,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [DATA_WIDTH-1:0]            req_wdata,
    input  logic [DATA_WIDTH/WRAP_SIZE-1:0]  req_lane_en,
    output logic                             rsp_vld,
    input  logic                             rsp_rdy,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic                             init_done,
    output logic [ADDR_WIDTH-1:0]            sram_A,
    output logic                             sram_CEN,
    output logic [DATA_WIDTH-1:0]            sram_D,
    output logic                             sram_GWEN,
    output logic [DATA_WIDTH-1:0]            sram_WEN,
    input  logic [DATA_WIDTH-1:0]            sram_Q
);

    localparam int LANES = DATA_WIDTH / WRAP_SIZE;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e                  state_q,     state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q,       cnt_d;
    logic                    init_done_q, init_done_d;
    logic                    inflight_q,  inflight_d;
    logic [ADDR_WIDTH-1:0]   last_a_q,    last_a_d;
    logic [DATA_WIDTH-1:0]   buf_q [2];
    logic [DATA_WIDTH-1:0]   buf_d [2];
    logic                    wr_ptr_q,    wr_ptr_d;
    logic                    rd_ptr_q,    rd_ptr_d;
    logic [1:0]              occ_q,       occ_d;

    logic [2:0]              pending;
    logic                    rd_ok;
    logic                    accept;
    logic                    push;
    logic                    pop;

    // Request side: readiness and the combinational SRAM pin drive.
    always_comb begin
        // A read may only be accepted if its response is guaranteed a slot.
        pending = {1'b0, occ_q} + {2'b00, inflight_q};
        rd_ok   = (pending < 3'd2);
        req_rdy = !RST && (state_q == S_RUN) && (req_wr || rd_ok);
        accept  = req_vld && req_rdy;

        sram_CEN  = 1'b1;
        sram_GWEN = 1'b1;
        sram_WEN  = '1;
        sram_D    = '0;
        sram_A    = last_a_q;

        if (RST) begin
            sram_A = '0;
        end else if (state_q == S_INIT) begin
            sram_CEN  = 1'b0;
            sram_GWEN = 1'b0;
            sram_WEN  = '0;
            sram_A    = cnt_q;
        end else if (accept) begin
            sram_CEN = 1'b0;
            sram_A   = req_addr;
            if (req_wr) begin
                // GWEN stays low even with no lanes enabled; WEN all high
                // then leaves the entry untouched.
                sram_GWEN = 1'b0;
                sram_D    = req_wdata;
                for (int i = 0; i < LANES; i++) begin
                    sram_WEN[i*WRAP_SIZE +: WRAP_SIZE] = {WRAP_SIZE{~req_lane_en[i]}};
                end
            end
        end
    end

    // Response side: 2-entry FIFO with a bypass path from sram_Q when empty.
    always_comb begin
        rsp_vld  = !RST && ((occ_q != 2'd0) || inflight_q);
        rsp_data = (occ_q != 2'd0) ? buf_q[rd_ptr_q] : sram_Q;
        pop      = rsp_rdy && (occ_q != 2'd0);
        // A bypassed response that is consumed immediately never enters
        // the buffer.
        push     = inflight_q && !((occ_q == 2'd0) && rsp_rdy);

        buf_d = buf_q;
        if (push) begin
            buf_d[wr_ptr_q] = sram_Q;
        end
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        occ_d    = occ_q + 2'(push) - 2'(pop);
    end

    // Control next-state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        if (state_q == S_INIT) begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == '1) begin
                state_d     = S_RUN;
                init_done_d = 1'b1;
            end
        end
        inflight_d = accept && !req_wr;
        last_a_d   = sram_CEN ? last_a_q : sram_A;
    end

    assign init_done = init_done_q;

    always_ff @(posedge CLK) begin
        // Buffer payload carries no reset; occupancy qualifies it.
        buf_q <= buf_d;
        if (RST) begin
            state_q     <= INIT_EN ? S_INIT : S_RUN;
            cnt_q       <= '0;
            init_done_q <= !INIT_EN;
            inflight_q  <= 1'b0;
            last_a_q    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            inflight_q  <= inflight_d;
            last_a_q    <= last_a_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
        end
    end

endmodule

// File: tb/tb_ct_f_spsram_128x104_ctrl.sv
// Testbench for ct_f_spsram_128x104_ctrl: behavioural SRAM model, directed
// stimulus, scoreboard queue of expected read data popped by a monitor.
module tb_ct_f_spsram_128x104_ctrl;

    localparam int AW = 7;
    localparam int DW = 104;
    localparam int LN = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          req_vld;
    logic          req_rdy;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [LN-1:0] req_lane_en;
    logic          rsp_vld;
    logic          rsp_rdy;
    logic [DW-1:0] rsp_data;
    logic          init_done;
    logic [AW-1:0] sram_A;
    logic          sram_CEN;
    logic [DW-1:0] sram_D;
    logic          sram_GWEN;
    logic [DW-1:0] sram_WEN;
    logic [DW-1:0] sram_Q;

    always #5 CLK = ~CLK;

    ct_f_spsram_128x104_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_vld    (req_vld),
        .req_rdy    (req_rdy),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_lane_en(req_lane_en),
        .rsp_vld    (rsp_vld),
        .rsp_rdy    (rsp_rdy),
        .rsp_data   (rsp_data),
        .init_done  (init_done),
        .sram_A     (sram_A),
        .sram_CEN   (sram_CEN),
        .sram_D     (sram_D),
        .sram_GWEN  (sram_GWEN),
        .sram_WEN   (sram_WEN),
        .sram_Q     (sram_Q)
    );

    // SRAM model. While reset is held the array is filled with a non-zero
    // pattern so that the zero-fill sweep has a visible effect.
    logic [DW-1:0] mem [128];
    always @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 128; i++) mem[i] <= {4{26'h2A5A5A5}} ^ DW'(i + 1);
            sram_Q <= {4{26'h1C3C3C3}};
        end else if (!sram_CEN) begin
            if (!sram_GWEN) mem[sram_A] <= (mem[sram_A] & sram_WEN) | (sram_D & ~sram_WEN);
            else            sram_Q      <= mem[sram_A];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] exp_q [$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each response transfer and checks
    // that a stalled response holds its data.
    logic          hold_flag = 1'b0;
    logic [DW-1:0] held;
    always @(negedge CLK) begin
        if (hold_flag && !RST) begin
            check("rsp_hold_vld", DW'(rsp_vld), DW'(1));
            check("rsp_hold_data", rsp_data, held);
        end
        if (rsp_vld && rsp_rdy) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_unexpected: got %h expected no response", rsp_data);
            end else begin
                check("rsp_data", rsp_data, exp_q.pop_front());
            end
        end
        hold_flag = rsp_vld && !rsp_rdy && !RST;
        held      = rsp_data;
    end

    // One-cycle request offer; call at posedge+1, returns at next posedge+1.
    task automatic drive(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [LN-1:0] le, output logic acc, output logic vld);
        req_vld     = 1'b1;
        req_wr      = wr;
        req_addr    = a;
        req_wdata   = d;
        req_lane_en = le;
        @(negedge CLK);
        acc = req_rdy;
        vld = rsp_vld;
        @(posedge CLK);
        #1;
    endtask

    // Offer until accepted (bounded); reads push their expected data.
    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [LN-1:0] le, input logic [DW-1:0] exp_rd, output logic vld);
        logic acc;
        logic done;
        done = 1'b0;
        vld  = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            drive(wr, a, d, le, acc, vld);
            if (acc) begin
                done = 1'b1;
                if (!wr) exp_q.push_back(exp_rd);
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_timeout: addr %h not accepted within 20 cycles", a);
        end
    endtask

    task automatic idle();
        req_vld = 1'b0;
        req_wr  = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Checks the 128-cycle zero-fill sweep starting on the current cycle.
    task automatic check_sweep();
        logic [12:0] act;
        logic [12:0] exp;
        for (int i = 0; i < 128; i++) begin
            @(negedge CLK);
            act = {sram_CEN, sram_GWEN, |sram_WEN, |sram_D, sram_A, req_rdy, init_done};
            exp = {4'b0000, AW'(i), 2'b00};
            check("init_sweep", DW'(act), DW'(exp));
        end
        @(negedge CLK);
        check("init_done_set", DW'(init_done), DW'(1));
        check("run_idle_cen", DW'(sram_CEN), DW'(1));
        check("run_rd_rdy", DW'(req_rdy), DW'(1));
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic          vld;
        logic          acc;
        int            acc_cnt;
        logic [DW-1:0] lane_exp;

        RST = 1'b1; req_vld = 1'b0; req_wr = 1'b0; req_addr = '0;
        req_wdata = '0; req_lane_en = '0; rsp_rdy = 1'b1;
        cycles(3);

        // Reset state
        @(negedge CLK);
        check("rst_req_rdy", DW'(req_rdy), DW'(0));
        check("rst_rsp_vld", DW'(rsp_vld), DW'(0));
        check("rst_init_done", DW'(init_done), DW'(0));
        check("rst_cen", DW'(sram_CEN), DW'(1));
        check("rst_gwen", DW'(sram_GWEN), DW'(1));
        check("rst_wen", sram_WEN, {DW{1'b1}});
        check("rst_addr", DW'(sram_A), DW'(0));
        check("rst_d", sram_D, DW'(0));
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check_sweep();

        // Zero-filled entry reads back as 0
        issue(1'b0, 7'h55, '0, '0, DW'(0), vld);
        idle();
        cycles(2);

        // Lane-masked overwrite: lanes 3 and 1 keep all-ones
        lane_exp = {{26{1'b1}}, 26'd0, {26{1'b1}}, 26'd0};
        issue(1'b1, 7'h10, {DW{1'b1}}, 4'b1111, '0, vld);
        issue(1'b1, 7'h10, DW'(0), 4'b0101, '0, vld);
        issue(1'b0, 7'h10, '0, '0, lane_exp, vld);
        idle();
        cycles(2);

        // Back-to-back reads, one response per cycle
        for (int a = 1; a <= 5; a++) issue(1'b1, AW'(a), DW'(a), 4'b1111, '0, vld);
        for (int a = 1; a <= 5; a++) begin
            issue(1'b0, AW'(a), '0, '0, DW'(a), vld);
            if (a > 1) check("b2b_rsp_vld", DW'(vld), DW'(1));
        end
        idle();
        @(negedge CLK);
        check("b2b_last_vld", DW'(rsp_vld), DW'(1));
        @(posedge CLK);
        #1;
        cycles(1);

        // Back-pressure: two reads fill the buffer, writes still pass
        rsp_rdy = 1'b0;
        acc_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, AW'(acc_cnt + 1), '0, '0, acc, vld);
            if (acc) begin
                exp_q.push_back(DW'(acc_cnt + 1));
                acc_cnt++;
            end
        end
        check("full_rd_accepts", DW'(acc_cnt), DW'(2));
        drive(1'b1, 7'h30, DW'(104'h123), 4'b1111, acc, vld);
        check("full_wr_accept", DW'(acc), DW'(1));
        idle();
        cycles(3);
        rsp_rdy = 1'b1;
        issue(1'b0, 7'h03, '0, '0, DW'(3), vld);
        issue(1'b0, 7'h04, '0, '0, DW'(4), vld);
        issue(1'b0, 7'h30, '0, '0, DW'(104'h123), vld);
        idle();
        cycles(3);

        // Read directly after a single-lane write to the same address
        issue(1'b1, 7'h20, DW'(104'hABC), 4'b0001, '0, vld);
        issue(1'b0, 7'h20, '0, '0, DW'(104'hABC), vld);
        idle();
        cycles(2);

        // Reset with one buffered response and one read in flight
        rsp_rdy = 1'b0;
        drive(1'b0, 7'h01, '0, '0, acc, vld);
        check("prerst_acc0", DW'(acc), DW'(1));
        drive(1'b0, 7'h02, '0, '0, acc, vld);
        check("prerst_acc1", DW'(acc), DW'(1));
        idle();
        RST = 1'b1;
        @(negedge CLK);
        check("midrst_rsp_vld", DW'(rsp_vld), DW'(0));
        check("midrst_req_rdy", DW'(req_rdy), DW'(0));
        check("midrst_cen", DW'(sram_CEN), DW'(1));
        @(posedge CLK);
        #1;
        RST = 1'b0;
        rsp_rdy = 1'b1;
        check_sweep();
        issue(1'b0, 7'h20, '0, '0, DW'(0), vld);
        idle();
        cycles(3);
        check("scoreboard_drained", DW'(exp_q.size()), DW'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
